// File: rtl/octave_pkg.sv
// Shared encodings and shift arithmetic for the octave synthesiser.
package octave_pkg;

    typedef enum logic [1:0] {
        OCT_UNISON = 2'b00,
        OCT_UP1    = 2'b01,
        OCT_DOWN1  = 2'b10,
        OCT_UP2    = 2'b11
    } oct_sel_e;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [13:0] AMPL_DEFAULT       = 14'h1000;
    localparam logic [31:0] MIN_PERIOD_DEFAULT = 32'd16;
    localparam logic [31:0] MAX_PERIOD_DEFAULT = 32'h0100_0000;

    // Period after the octave shift; MAX_PERIOD bound keeps the x2 case in range.
    function automatic logic [31:0] shift_period(input logic [31:0] p, input oct_sel_e sel);
        case (sel)
            OCT_UP1:   return p >> 1;
            OCT_UP2:   return p >> 2;
            OCT_DOWN1: return p << 1;
            default:   return p;
        endcase
    endfunction

    // Half period in cycles, never zero so the toggle compare stays meaningful.
    function automatic logic [31:0] half_of(input logic [31:0] s);
        logic [31:0] h;
        h = s >> 1;
        return (h == 32'd0) ? 32'd1 : h;
    endfunction

endpackage

// File: rtl/octave_synth_nco.sv
// Half-period counter with toggle output and a one-deep pending reload.
// A reload request never disturbs the half-period in flight; it is held
// and applied at the next toggle. tag carries the shifted period alongside.
module half_period_nco (
    input  logic        CLK_IN,
    input  logic        RST_N,
    input  logic        run,
    input  logic        clear,
    input  logic        load,
    input  logic        reload_req,
    input  logic [31:0] half_in,
    input  logic [31:0] tag_in,
    output logic        square,
    output logic [31:0] tag_out
);
    logic [31:0] cnt;
    logic [31:0] half;
    logic [31:0] pend_half;
    logic [31:0] pend_tag;
    logic        pend;
    logic        boundary;

    assign boundary = (cnt == half - 32'd1);

    // Count, toggle at the half-period boundary, swap in pending values there.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            cnt       <= '0;
            half      <= 32'd1;
            pend_half <= '0;
            pend_tag  <= '0;
            pend      <= 1'b0;
            square    <= 1'b0;
            tag_out   <= '0;
        end else if (clear) begin
            cnt     <= '0;
            pend    <= 1'b0;
            square  <= 1'b0;
            tag_out <= '0;
        end else if (load) begin
            cnt     <= '0;
            half    <= half_in;
            tag_out <= tag_in;
            pend    <= 1'b0;
            square  <= 1'b1;
        end else if (run) begin
            if (boundary) begin
                square <= ~square;
                cnt    <= '0;
                if (pend) begin
                    half    <= pend_half;
                    tag_out <= pend_tag;
                    pend    <= 1'b0;
                end
            end else begin
                cnt <= cnt + 32'd1;
            end
            // A request on the boundary cycle lands here after the swap, so it
            // waits for the following boundary; the latest request wins.
            if (reload_req) begin
                pend_half <= half_in;
                pend_tag  <= tag_in;
                pend      <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/octave_synth.sv
// Octave-shifted square tone from the detector's measured period.
// Captures periodo/octave_sel, flags changes as updates, validates them
// and drives the IDLE/RUN state machine around the half-period NCO.
module octave_synth
    import octave_pkg::*;
#(
    parameter logic [31:0] MIN_PERIOD = MIN_PERIOD_DEFAULT,
    parameter logic [31:0] MAX_PERIOD = MAX_PERIOD_DEFAULT,
    parameter logic [13:0] AMPL       = AMPL_DEFAULT
) (
    input  logic        CLK_IN,
    input  logic        RST_N,
    input  logic [31:0] periodo,
    input  logic [1:0]  octave_sel,
    input  logic        enable,
    output logic        square_out,
    output logic [13:0] data_out,
    output logic        period_valid,
    output logic [31:0] periodo_act
);
    localparam logic [13:0] NEG_AMPL = ~AMPL + 14'd1;

    logic [31:0] periodo_r, periodo_q;
    logic [1:0]  sel_r, sel_q;
    logic        primed;
    logic [0:0]  state, state_d;
    logic        upd, in_range;
    logic [31:0] shifted, half;
    logic        load, clear, reload_req, run;
    logic        sq;

    // Input capture; the first capture after reset seeds both stages so a
    // value held across reset is not mistaken for an update.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            periodo_r <= '0;
            periodo_q <= '0;
            sel_r     <= '0;
            sel_q     <= '0;
            primed    <= 1'b0;
        end else if (!primed) begin
            periodo_r <= periodo;
            periodo_q <= periodo;
            sel_r     <= octave_sel;
            sel_q     <= octave_sel;
            primed    <= 1'b1;
        end else begin
            periodo_r <= periodo;
            periodo_q <= periodo_r;
            sel_r     <= octave_sel;
            sel_q     <= sel_r;
        end
    end

    assign upd      = (periodo_r != periodo_q) || (sel_r != sel_q);
    assign in_range = (periodo_r >= MIN_PERIOD) && (periodo_r <= MAX_PERIOD);
    assign shifted  = shift_period(periodo_r, oct_sel_e'(sel_r));
    assign half     = half_of(shifted);

    // Next state; invalid update or enable low silences before any toggle.
    always_comb begin
        state_d    = state;
        load       = 1'b0;
        clear      = 1'b0;
        reload_req = 1'b0;
        if (state == ST_IDLE) begin
            if (upd && in_range && enable) begin
                load    = 1'b1;
                state_d = ST_RUN;
            end
        end else begin
            if (!enable || (upd && !in_range)) begin
                clear   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                reload_req = upd;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_d;
    end

    assign run = (state == ST_RUN);

    half_period_nco u_nco (
        .CLK_IN     (CLK_IN),
        .RST_N      (RST_N),
        .run        (run),
        .clear      (clear),
        .load       (load),
        .reload_req (reload_req),
        .half_in    (half),
        .tag_in     (shifted),
        .square     (sq),
        .tag_out    (periodo_act)
    );

    assign square_out   = sq;
    assign period_valid = run;
    assign data_out     = run ? (sq ? AMPL : NEG_AMPL) : 14'd0;

endmodule
